mem_arbiter: RTL and testbench

Two-master, one-slave arbiter for the core's single memory port. It lets the core (master 0) and a second requester, such as a program loader or debug/DMA engine (master 1), share one memory. Both masters and the memory use the core's valid/ready read/write handshake. The arbiter grants one master at a time with round-robin fairness and holds the grant until that master's transfer completes. A watchdog forcibly releases a grant that stalls too long.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/rr_pick2.sv | 31 +++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_pkg                                                              |
// | Shared types and constants for the memory-port arbiter:             |
// | arbiter state encoding, one-hot grant codes, last-grant indices.    |
// | DATA_WIDTH remains the global macro; a fallback is provided here.   |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // One-hot owner codes driven on o_grant.
    localparam logic [1:0] c_GRANT_NONE = 2'b00;
    localparam logic [1:0] c_GRANT_M0   = 2'b01;
    localparam logic [1:0] c_GRANT_M1   = 2'b10;

    // last_grant holds the index of the master that won the previous tie.
    localparam logic c_LAST_M0 = 1'b0;
    localparam logic c_LAST_M1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick2                                                             |
// | Combinational two-input round-robin picker.                         |
// | Ports: i_req  [1:0] request vector (bit N = master N)               |
// |        i_last       index of the master that won the previous tie   |
// |        o_pick [1:0] one-hot pick, 00 when nobody requests           |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module rr_pick2
    import mem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_pick
);

    always_comb begin
        o_pick = c_GRANT_NONE;
        case (i_req)
            2'b01:   o_pick = c_GRANT_M0;
            2'b10:   o_pick = c_GRANT_M1;
            // On a tie the master that did not win last time gets the port.
            2'b11:   o_pick = (i_last == c_LAST_M1) ? c_GRANT_M0 : c_GRANT_M1;
            default: o_pick = c_GRANT_NONE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter                                                          |
// | Two-master / one-slave round-robin arbiter for the memory port.     |
// | Ports: i_clk, i_rst (sync, active high)                             |
// |        i_m{0,1}_* / o_m{0,1}_* master valid/ready read-write ports  |
// |        o_addr/o_data/o_wr_valid/i_wr_ready   memory write side      |
// |        i_data/i_rd_valid/o_rd_ready          memory read side       |
// |        o_grant  one-hot owner, o_timeout  forced-release pulse      |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DW             = `DATA_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [31:0]   i_m0_addr,
    input  logic [31:0]   i_m1_addr,
    input  logic [DW-1:0] i_m0_data,
    input  logic [DW-1:0] i_m1_data,
    input  logic          i_m0_wr_valid,
    input  logic          i_m1_wr_valid,
    output logic          o_m0_wr_ready,
    output logic          o_m1_wr_ready,
    output logic [DW-1:0] o_m0_data,
    output logic [DW-1:0] o_m1_data,
    output logic          o_m0_rd_valid,
    output logic          o_m1_rd_valid,
    input  logic          i_m0_rd_ready,
    input  logic          i_m1_rd_ready,
    output logic [31:0]   o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_wr_valid,
    input  logic          i_wr_ready,
    input  logic [DW-1:0] i_data,
    input  logic          i_rd_valid,
    output logic          o_rd_ready,
    output logic [1:0]    o_grant,
    output logic          o_timeout
);

    // Counter must be able to reach TIMEOUT_CYCLES-1; one bit minimum.
    localparam int c_CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t         state_q;
    logic               last_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [1:0]         grant_q;

    logic [1:0] w_req;
    logic [1:0] w_pick;
    logic       w_owner_req;
    logic       w_done;
    logic       w_timeout;

    assign w_req = {i_m1_wr_valid | i_m1_rd_ready, i_m0_wr_valid | i_m0_rd_ready};

    rr_pick2 u_pick (
        .i_req  (w_req),
        .i_last (last_q),
        .o_pick (w_pick)
    );

    // Owner passthrough; everything reads as zero for the non-owner and in IDLE.
    always_comb begin
        o_addr        = '0;
        o_data        = '0;
        o_wr_valid    = 1'b0;
        o_rd_ready    = 1'b0;
        o_m0_wr_ready = 1'b0;
        o_m0_rd_valid = 1'b0;
        o_m0_data     = '0;
        o_m1_wr_ready = 1'b0;
        o_m1_rd_valid = 1'b0;
        o_m1_data     = '0;
        w_owner_req   = 1'b0;
        case (state_q)
            OWN0: begin
                o_addr        = i_m0_addr;
                o_data        = i_m0_data;
                o_wr_valid    = i_m0_wr_valid;
                // A write wins when the owner asserts both directions.
                o_rd_ready    = i_m0_rd_ready & ~i_m0_wr_valid;
                o_m0_wr_ready = i_wr_ready;
                o_m0_rd_valid = i_rd_valid;
                o_m0_data     = i_data;
                w_owner_req   = w_req[0];
            end
            OWN1: begin
                o_addr        = i_m1_addr;
                o_data        = i_m1_data;
                o_wr_valid    = i_m1_wr_valid;
                o_rd_ready    = i_m1_rd_ready & ~i_m1_wr_valid;
                o_m1_wr_ready = i_wr_ready;
                o_m1_rd_valid = i_rd_valid;
                o_m1_data     = i_data;
                w_owner_req   = w_req[1];
            end
            default: ;
        endcase
    end

    assign w_done = (o_wr_valid & i_wr_ready) | (i_rd_valid & o_rd_ready);

    // Forced release fires in the last allowed owned cycle. A completion in
    // that cycle wins, and an owner that has dropped its request is an abort.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) && w_owner_req
                       && !w_done && (cnt_q == c_CNT_LAST);
    assign o_timeout = w_timeout;
    assign o_grant   = grant_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= c_LAST_M1;
            cnt_q   <= '0;
            grant_q <= c_GRANT_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (w_pick == c_GRANT_M0) begin
                        state_q <= OWN0;
                        grant_q <= c_GRANT_M0;
                    end else if (w_pick == c_GRANT_M1) begin
                        state_q <= OWN1;
                        grant_q <= c_GRANT_M1;
                    end
                    // Only contested grants move the round-robin pointer.
                    if (&w_req) begin
                        last_q <= w_pick[1];
                    end
                end
                OWN0, OWN1: begin
                    if (w_done || !w_owner_req || w_timeout) begin
                        state_q <= IDLE;
                        grant_q <= c_GRANT_NONE;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= c_GRANT_NONE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_arbiter                                                       |
// | Directed scenarios plus randomized traffic against a transaction-   |
// | level model of ownership, fairness and the watchdog.                |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mem_arbiter;

    localparam int DW = `DATA_WIDTH;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [1:0]    m_wv;
    logic [1:0]    m_rr;
    logic          i_wr_ready;
    logic          i_rd_valid;
    logic [DW-1:0] i_data;

    logic          o_m0_wr_ready, o_m1_wr_ready;
    logic          o_m0_rd_valid, o_m1_rd_valid;
    logic [DW-1:0] o_m0_data, o_m1_data;
    logic [31:0]   o_addr;
    logic [DW-1:0] o_data;
    logic          o_wr_valid, o_rd_ready, o_timeout;
    logic [1:0]    o_grant;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .DW(DW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_m0_addr     (m_addr[0]),
        .i_m1_addr     (m_addr[1]),
        .i_m0_data     (m_wdata[0]),
        .i_m1_data     (m_wdata[1]),
        .i_m0_wr_valid (m_wv[0]),
        .i_m1_wr_valid (m_wv[1]),
        .o_m0_wr_ready (o_m0_wr_ready),
        .o_m1_wr_ready (o_m1_wr_ready),
        .o_m0_data     (o_m0_data),
        .o_m1_data     (o_m1_data),
        .o_m0_rd_valid (o_m0_rd_valid),
        .o_m1_rd_valid (o_m1_rd_valid),
        .i_m0_rd_ready (m_rr[0]),
        .i_m1_rd_ready (m_rr[1]),
        .o_addr        (o_addr),
        .o_data        (o_data),
        .o_wr_valid    (o_wr_valid),
        .i_wr_ready    (i_wr_ready),
        .i_data        (i_data),
        .i_rd_valid    (i_rd_valid),
        .o_rd_ready    (o_rd_ready),
        .o_grant       (o_grant),
        .o_timeout     (o_timeout)
    );

    int checks = 0;
    int fails  = 0;

    // Model: owner index (-1 = nobody), cycles owned so far, last tie winner.
    int own   = -1;
    int cnt   = 0;
    int lastg = 1;
    logic [1:0] e_req;
    logic       e_done;
    logic       e_to;
    int         done_m = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership update at each clock edge from the inputs seen that cycle.
    always @(posedge clk) begin
        if (rst) begin
            own = -1; cnt = 0; lastg = 1;
        end else if (own < 0) begin
            if (e_req == 2'b11) begin
                own = 1 - lastg;
                lastg = own;
            end else if (e_req[0]) begin
                own = 0;
            end else if (e_req[1]) begin
                own = 1;
            end
            cnt = 0;
        end else if (e_done || !e_req[own] || e_to) begin
            own = -1;
        end else begin
            cnt++;
        end
    end

    task automatic compare_all();
        logic [1:0]    eg;
        logic [31:0]   ea;
        logic [DW-1:0] ed;
        logic          ewv, err;
        e_req = m_wv | m_rr;
        eg = 2'b00; ea = '0; ed = '0; ewv = 1'b0; err = 1'b0;
        e_done = 1'b0; e_to = 1'b0;
        if (own >= 0) begin
            eg     = (own == 0) ? 2'b01 : 2'b10;
            ea     = m_addr[own];
            ed     = m_wdata[own];
            ewv    = m_wv[own];
            err    = m_rr[own] & ~m_wv[own];
            e_done = (ewv & i_wr_ready) | (err & i_rd_valid);
            e_to   = e_req[own] & ~e_done & (cnt == TO - 1);
        end
        done_m = e_done ? own : -1;
        chk("grant",      o_grant,    eg);
        chk("mem_addr",   o_addr,     ea);
        chk("mem_wdata",  o_data,     ed);
        chk("mem_wvalid", o_wr_valid, ewv);
        chk("mem_rready", o_rd_ready, err);
        chk("timeout",    o_timeout,  e_to);
        chk("m0_wready", o_m0_wr_ready, (own == 0) ? i_wr_ready : 1'b0);
        chk("m1_wready", o_m1_wr_ready, (own == 1) ? i_wr_ready : 1'b0);
        chk("m0_rvalid", o_m0_rd_valid, (own == 0) ? i_rd_valid : 1'b0);
        chk("m1_rvalid", o_m1_rd_valid, (own == 1) ? i_rd_valid : 1'b0);
        chk("m0_rdata",  o_m0_data, (own == 0) ? i_data : '0);
        chk("m1_rdata",  o_m1_data, (own == 1) ? i_data : '0);
    endtask

    // Compare on the falling edge, then move to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] pend [2];

    initial begin
        rst = 1'b1;
        m_addr[0] = '0; m_addr[1] = '0; m_wdata[0] = '0; m_wdata[1] = '0;
        m_wv = 2'b00; m_rr = 2'b00;
        i_wr_ready = 1'b0; i_rd_valid = 1'b0; i_data = '0;
        pend[0] = 2'b00; pend[1] = 2'b00;

        // Reset
        @(posedge clk); #1;
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_wvalid", o_wr_valid, 1'b0);
        chk("rst_rready", o_rd_ready, 1'b0);
        chk("rst_addr", o_addr, 32'h0);
        rst = 1'b0;

        // Solo read by m0
        m_rr[0] = 1'b1; m_addr[0] = 32'h0;
        step();
        chk("solo_grant", o_grant, 2'b01);
        chk("solo_addr", o_addr, 32'h0);
        chk("solo_rready", o_rd_ready, 1'b1);
        i_data = 32'h00500293; i_rd_valid = 1'b1; #1;
        chk("solo_rvalid", o_m0_rd_valid, 1'b1);
        chk("solo_rdata", o_m0_data, 32'h00500293);
        step();
        m_rr[0] = 1'b0; i_rd_valid = 1'b0; #1;
        chk("solo_release", o_grant, 2'b00);

        // Tie then fairness
        m_rr = 2'b11; m_addr[0] = 32'h10; m_addr[1] = 32'h100;
        step();
        chk("tie_first", o_grant, 2'b01);
        i_rd_valid = 1'b1;
        step();
        i_rd_valid = 1'b0; #1;
        chk("tie_bubble", o_grant, 2'b00);
        step();
        chk("tie_second", o_grant, 2'b10);
        chk("tie_m1_addr", o_addr, 32'h100);
        i_rd_valid = 1'b1;
        step();
        m_rr[1] = 1'b0; i_rd_valid = 1'b0; #1;
        chk("tie_bubble2", o_grant, 2'b00);
        step();
        chk("tie_m0_again", o_grant, 2'b01);
        m_rr[0] = 1'b0;
        step();
        chk("abort_idle", o_grant, 2'b00);

        // Stalled write by m1 with m0 read pending
        m_wv[1] = 1'b1; m_addr[1] = 32'h7BC; m_wdata[1] = 32'hC000; i_wr_ready = 1'b0;
        step();
        m_rr[0] = 1'b1; m_addr[0] = 32'h40; #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_grant", o_grant, 2'b10);
            chk("stall_wvalid", o_wr_valid, 1'b1);
            chk("stall_wready", o_m1_wr_ready, 1'b0);
            chk("stall_addr", o_addr, 32'h7BC);
            chk("stall_data", o_data, 32'hC000);
            step();
        end
        i_wr_ready = 1'b1; #1;
        chk("stall_done", o_m1_wr_ready, 1'b1);
        step();
        m_wv[1] = 1'b0; i_wr_ready = 1'b0; #1;
        chk("stall_bubble", o_grant, 2'b00);
        step();
        chk("pending_m0", o_grant, 2'b01);
        i_rd_valid = 1'b1; i_data = 32'h1234_5678; #1;
        chk("pending_rdata", o_m0_data, 32'h1234_5678);
        step();
        m_rr[0] = 1'b0; i_rd_valid = 1'b0;

        // Watchdog: timeout on the 8th owned cycle, none when completing there
        step();
        m_rr[0] = 1'b1; m_addr[0] = 32'h80;
        step();
        for (int i = 1; i < TO; i++) begin
            chk("wd_quiet", o_timeout, 1'b0);
            step();
        end
        chk("wd_pulse", o_timeout, 1'b1);
        chk("wd_grant", o_grant, 2'b01);
        step();
        chk("wd_idle", o_grant, 2'b00);
        chk("wd_pulse_end", o_timeout, 1'b0);
        step();
        chk("wd_regrant", o_grant, 2'b01);
        for (int i = 1; i < TO; i++) step();
        i_rd_valid = 1'b1; i_data = 32'hA5A5_0001; #1;
        chk("wd_complete_no_pulse", o_timeout, 1'b0);
        chk("wd_complete_rvalid", o_m0_rd_valid, 1'b1);
        step();
        m_rr[0] = 1'b0; i_rd_valid = 1'b0; #1;
        chk("wd_complete_idle", o_grant, 2'b00);

        // Reset during an m1 write
        m_wv[1] = 1'b1; m_addr[1] = 32'h200; m_wdata[1] = 32'hBEEF;
        step();
        chk("rstw_grant", o_grant, 2'b10);
        rst = 1'b1;
        step();
        rst = 1'b0; i_wr_ready = 1'b1; #1;
        chk("rstw_grant_drop", o_grant, 2'b00);
        chk("rstw_no_wready", o_m1_wr_ready, 1'b0);
        step();
        m_wv[1] = 1'b0; i_wr_ready = 1'b0;
        step();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                if (pend[k] != 2'b00 && (done_m == k || $urandom_range(0, 31) == 0)) begin
                    pend[k] = 2'b00;
                end else if (pend[k] == 2'b00 && $urandom_range(0, 2) == 0) begin
                    pend[k]    = 2'($urandom_range(1, 3));
                    m_addr[k]  = $urandom;
                    m_wdata[k] = DW'($urandom);
                end
                m_wv[k] = pend[k][1];
                m_rr[k] = pend[k][0];
            end
            i_wr_ready = ($urandom_range(0, 3) == 0);
            i_rd_valid = ($urandom_range(0, 3) == 0);
            i_data     = DW'($urandom);
            step();
        end

        rst = 1'b0; m_wv = 2'b00; m_rr = 2'b00; i_wr_ready = 1'b0; i_rd_valid = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
